// File: rtl/ee354_btn_move_if.sv
// Button-to-move interface.
// Carries the raw push-button levels and the downstream ready flag into the move block.
// Carries the single-cycle move pulses and the FSM state flags back out.
//   BtnU/BtnD/BtnL/BtnR : raw bouncing button levels, high = pressed
//   ready               : downstream game FSM can accept a move
//   up/down/left/right  : one-cycle move pulses, at most one high at a time
//   pending             : a captured move is waiting for ready
//   q_Idle/q_Pend/q_Hold: one-hot move FSM state
// master: the side that owns the buttons and the game FSM (drives inputs).
// slave : the move block itself.
interface ee354_btn_move_if;
  logic BtnU;
  logic BtnD;
  logic BtnL;
  logic BtnR;
  logic ready;
  logic up;
  logic down;
  logic left;
  logic right;
  logic pending;
  logic q_Idle;
  logic q_Pend;
  logic q_Hold;

  modport master (
    output BtnU, BtnD, BtnL, BtnR, ready,
    input  up, down, left, right, pending, q_Idle, q_Pend, q_Hold
  );

  modport slave (
    input  BtnU, BtnD, BtnL, BtnR, ready,
    output up, down, left, right, pending, q_Idle, q_Pend, q_Hold
  );
endinterface

// File: rtl/ee354_btn_move.sv
// Push-button move generator.
// Four raw button levels are synchronised and debounced.
// A small move FSM then turns a debounced press into exactly one registered move pulse.
// That pulse is handed to the downstream game FSM once it signals ready.
// A held button yields one pulse only.
// The FSM re-arms only after every button has been released.
//   Clk   : sole clock, rising edge
//   Reset : asynchronous, active-high; clears all state
//   bus   : ee354_btn_move_if slave modport (buttons, ready, moves, state flags)
// Parameter DEBOUNCE_COUNT (2..2^24): consecutive cycles a synchronised input must
// differ from its stable level before the stable level follows it.
module ee354_btn_move #(
  parameter int unsigned DEBOUNCE_COUNT = 1000000
) (
  input logic              Clk,
  input logic              Reset,
  ee354_btn_move_if.slave  bus
);

  localparam logic [23:0] CntMax = 24'(DEBOUNCE_COUNT - 1);

  // Bit order used for every per-button vector: [3]=up, [2]=down, [1]=left, [0]=right.
  // This matches the capture priority up > down > left > right.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StPend = 3'b010,
    StHold = 3'b100
  } state_e;

  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       stable_q, stable_d;
  logic [3:0][23:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [3:0]       dir_q, dir_d;
  logic [3:0]       move_q, move_d;

  assign btn_raw = {bus.BtnU, bus.BtnD, bus.BtnL, bus.BtnR};

  // Two-flop synchroniser; nothing downstream ever looks at btn_raw or sync1_q.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer per button.
  // Any cycle where the input agrees with the stable level restarts the count.
  // So only an uninterrupted run of DEBOUNCE_COUNT differing cycles flips the level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 24'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Move FSM.
  // Direction is latched on entry to PEND and held there.
  // A later release or another press cannot alter or cancel the move.
  // Buttons are only looked at again in IDLE.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    move_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (|stable_q) begin
          state_d = StPend;
          if (stable_q[3]) begin
            dir_d = 4'b1000;
          end else if (stable_q[2]) begin
            dir_d = 4'b0100;
          end else if (stable_q[1]) begin
            dir_d = 4'b0010;
          end else begin
            dir_d = 4'b0001;
          end
        end
      end
      StPend: begin
        if (bus.ready) begin
          move_d  = dir_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (stable_q == 4'b0000) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      dir_q   <= '0;
      move_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
    end
  end

  assign bus.up      = move_q[3];
  assign bus.down    = move_q[2];
  assign bus.left    = move_q[1];
  assign bus.right   = move_q[0];
  assign bus.q_Idle  = state_q[0];
  assign bus.q_Pend  = state_q[1];
  assign bus.q_Hold  = state_q[2];
  assign bus.pending = state_q[1];

endmodule
